// File: rtl/bpu_param.sv
// Branch predictor: direct-mapped BTB/BHT with 2-bit counters and a correction FSM.
// Define BPU_RAS_EN to add a circular return-address stack.
module bpu_param #(
  parameter int ENTRIES   = 1024,
  parameter int RAS_DEPTH = 8,
  parameter int VA_W      = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush_i,
  input  logic [VA_W-1:0] pred_pc_i,
  input  logic [2:0]      pred_br_type_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  output logic [VA_W-1:0] pred_target_o,
  output logic            pred_hit_o,
  input  logic            upd_valid_i,
  input  logic [VA_W-1:0] upd_pc_i,
  input  logic [2:0]      upd_br_type_i,
  input  logic            upd_taken_i,
  input  logic [VA_W-1:0] upd_target_i,
  input  logic            upd_mispredict_i,
  output logic            corr_flush_o,
  output logic            corr_active_o,
  output logic [VA_W-1:0] corr_target_o,
  input  logic            corr_done_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = VA_W - 2 - IDX_W;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BRA  = 3'd1;
  localparam logic [2:0] BR_J    = 3'd2;
  localparam logic [2:0] BR_CALL = 3'd3;
  localparam logic [2:0] BR_RET  = 3'd4;

  typedef enum logic {IDLE, CORRECT} state_t;

  state_t state_q, state_d;
  logic [VA_W-1:0] ctgt_q, ctgt_d;

  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [VA_W-1:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] p_idx, u_idx;
  logic [TAG_W-1:0] p_tag, u_tag;
  logic             p_hit, u_hit;
  logic             p_type_ok, u_we;
  logic [VA_W-1:0]  p_seq;
  logic [1:0]       u_ctr;
  logic             ras_nonempty;
  logic [VA_W-1:0]  ras_top;

  assign p_idx = pred_pc_i[IDX_W+1:2];
  assign p_tag = pred_pc_i[VA_W-1:IDX_W+2];
  assign p_hit = vld_q[p_idx] && (tag_q[p_idx] == p_tag);
  assign p_seq = pred_pc_i + VA_W'(8);

  assign p_type_ok = (pred_br_type_i != BR_NONE) &&
                     (pred_br_type_i <= BR_RET);

  assign pred_valid_o = (state_q == IDLE) && p_type_ok;
  assign pred_hit_o   = p_hit;

  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = p_seq;
    if (p_hit) begin
      case (pred_br_type_i)
        BR_BRA: begin
          if (ctr_q[p_idx][1]) begin
            pred_taken_o  = 1'b1;
            pred_target_o = tgt_q[p_idx];
          end
        end
        BR_J, BR_CALL: begin
          pred_taken_o  = 1'b1;
          pred_target_o = tgt_q[p_idx];
        end
        BR_RET: begin
          pred_taken_o  = 1'b1;
          pred_target_o = ras_nonempty ? ras_top : tgt_q[p_idx];
        end
        default: ;
      endcase
    end
  end

  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[VA_W-1:IDX_W+2];
  assign u_hit = vld_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_we  = upd_valid_i && (upd_br_type_i != BR_NONE) &&
                 (upd_br_type_i <= BR_RET);

  always_comb begin
    u_ctr = upd_taken_i ? 2'd2 : 2'd1;
    if (u_hit) begin
      if (upd_taken_i)
        u_ctr = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
      else
        u_ctr = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'd0;
    end else if (u_we) begin
      vld_q[u_idx] <= 1'b1;
      ctr_q[u_idx] <= u_ctr;
    end
  end

  // Tag/target are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (u_we) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    ctgt_d       = ctgt_q;
    corr_flush_o = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      ctgt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (upd_valid_i && upd_mispredict_i) begin
            state_d      = CORRECT;
            corr_flush_o = 1'b1;
            ctgt_d       = upd_taken_i ? upd_target_i
                                       : upd_pc_i + VA_W'(8);
          end
        end
        CORRECT: begin
          if (corr_done_i)
            state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ctgt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctgt_q  <= ctgt_d;
    end
  end

  assign corr_active_o = (state_q == CORRECT);
  assign corr_target_o = ctgt_q;

`ifdef BPU_RAS_EN
  localparam int RP_W = $clog2(RAS_DEPTH);
  localparam logic [RP_W:0] RAS_FULL = (RP_W+1)'(RAS_DEPTH);

  logic [VA_W-1:0] ras_q [RAS_DEPTH];
  logic [RP_W-1:0] rptr_q;
  logic [RP_W:0]   rcnt_q;
  logic            push, pop;

  assign push = pred_valid_o && (pred_br_type_i == BR_CALL);
  assign pop  = pred_valid_o && (pred_br_type_i == BR_RET);

  assign ras_nonempty = (rcnt_q != '0);
  assign ras_top      = ras_q[rptr_q - RP_W'(1)];

  // rptr_q is the next free slot; overflow wraps over the oldest entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr_q <= '0;
      rcnt_q <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      rcnt_q <= '0;
    end else if (push) begin
      rptr_q <= rptr_q + RP_W'(1);
      if (rcnt_q != RAS_FULL)
        rcnt_q <= rcnt_q + (RP_W+1)'(1);
    end else if (pop && ras_nonempty) begin
      rptr_q <= rptr_q - RP_W'(1);
      rcnt_q <= rcnt_q - (RP_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i && push)
      ras_q[rptr_q] <= p_seq;
  end
`else
  assign ras_nonempty = 1'b0;
  assign ras_top      = '0;
`endif

endmodule
